neural_acc_neuron_engine: RTL

- Compute stage directly downstream of the neural_acc_v1_0 AXI4-Lite slave register bank.
- Consumes word-indexed register writes and reads from the slave: byte address >> 2.
- Buffers an input vector and a weight vector, then runs a sequential signed multiply-accumulate.
- Adds bias, applies optional ReLU, saturates to 32 bits, and exposes result and status for AXI readback.

---
 rtl/neural_acc_pkg.sv | 54 +++++
 rtl/neural_acc_mac.sv | 42 ++++
 rtl/neural_acc_neuron_engine.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neural_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neural_acc_pkg
//  Description : Shared register map, bit positions, FSM state type and
//                32-bit saturation helper for the neuron compute engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package neural_acc_pkg;

    // Register word indices (byte address >> 2)
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_LEN     = 3'd1;
    localparam logic [2:0] REG_IN_PUSH = 3'd2;
    localparam logic [2:0] REG_W_PUSH  = 3'd3;
    localparam logic [2:0] REG_BIAS    = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;
    localparam logic [2:0] REG_RESULT  = 3'd6;

    // CTRL bit positions
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_RELU_BIT  = 1;
    localparam int CTRL_CLEAR_BIT = 2;

    // STATUS bit positions
    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_OVF_BIT     = 2;
    localparam int STAT_LEN_ERR_BIT = 3;
    localparam int STAT_WR_ERR_BIT  = 4;
    localparam int STAT_IN_CNT_LSB  = 8;
    localparam int STAT_W_CNT_LSB   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic signed [63:0] c_S32_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] c_S32_MIN = 64'shFFFF_FFFF_8000_0000;

    // Clamp a signed 64-bit value into the signed 32-bit range
    function automatic logic [31:0] saturate_s32(input logic signed [63:0] value);
        if (value > c_S32_MAX) begin
            return 32'h7FFF_FFFF;
        end else if (value < c_S32_MIN) begin
            return 32'h8000_0000;
        end else begin
            return value[31:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/neural_acc_mac.sv
`default_nettype none
// ============================================================================
//  Module      : neural_acc_mac
//  Description : Signed multiply-accumulate. The full-width product is
//                sign-extended into the accumulator; clear has priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module neural_acc_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

    // Accumulator: cleared at the start of a run, one MAC per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/neural_acc_neuron_engine.sv
`default_nettype none
// ============================================================================
//  Module      : neural_acc_neuron_engine
//  Description : Register-mapped neuron: buffers input and weight vectors,
//                runs a sequential signed MAC, adds bias, optional ReLU and
//                32-bit saturation, and exposes result/status for readback.
//  Revision    : 1.0 - initial release
// ============================================================================
module neural_acc_neuron_engine
    import neural_acc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ACC_W  = 40
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        reg_wr_en,
    input  logic [2:0]  reg_wr_addr,
    input  logic [31:0] reg_wr_data,
    input  logic        reg_rd_en,
    input  logic [2:0]  reg_rd_addr,
    output logic [31:0] reg_rd_data,
    output logic        done_irq,
    output logic        busy
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_start_pend;
    logic                      r_relu_en;
    logic [3:0]                r_len;
    logic signed [DATA_W-1:0]  r_bias;
    logic signed [DATA_W-1:0]  r_in_buf [DEPTH];
    logic signed [DATA_W-1:0]  r_w_buf  [DEPTH];
    logic [c_CNT_W-1:0]        r_in_cnt;
    logic [c_CNT_W-1:0]        r_w_cnt;
    logic [c_IDX_W-1:0]        r_idx;
    logic                      r_done;
    logic                      r_ovf;
    logic                      r_len_err;
    logic                      r_wr_err;
    logic                      r_done_irq;
    logic [31:0]               r_result;
    logic [31:0]               r_rd_data;

    logic                      w_wr_ctrl;
    logic                      w_soft_clear;
    logic                      w_start_req;
    logic                      w_push_in;
    logic                      w_push_w;
    logic                      w_len_ok;
    logic                      w_idx_last;
    logic                      w_start_accept;
    logic                      w_len_bad;
    logic                      w_mac_en;
    logic                      w_mac_clear;
    logic                      w_finish;
    logic signed [ACC_W-1:0]   w_acc;
    logic signed [ACC_W-1:0]   w_biased;
    logic signed [ACC_W-1:0]   w_activated;
    logic [31:0]               w_status;
    logic [31:0]               w_rd_mux;
    logic                      w_unused_wr_data;

    // Write decode; soft_clear overrides a start written in the same word
    assign w_wr_ctrl    = reg_wr_en && (reg_wr_addr == REG_CTRL);
    assign w_soft_clear = w_wr_ctrl && reg_wr_data[CTRL_CLEAR_BIT];
    assign w_start_req  = w_wr_ctrl && reg_wr_data[CTRL_START_BIT] && !reg_wr_data[CTRL_CLEAR_BIT];
    assign w_push_in    = reg_wr_en && (reg_wr_addr == REG_IN_PUSH);
    assign w_push_w     = reg_wr_en && (reg_wr_addr == REG_W_PUSH);
    assign w_unused_wr_data = ^reg_wr_data[31:DATA_W];

    assign busy     = (r_state != IDLE);
    assign done_irq = r_done_irq;

    assign w_len_ok   = (r_len != 4'd0) && (int'(r_len) <= DEPTH)
                     && (int'(r_len) <= int'(r_in_cnt)) && (int'(r_len) <= int'(r_w_cnt));
    assign w_idx_last = (int'(r_idx) == int'(r_len) - 1);

    // Post-processing of the accumulator: bias, optional ReLU
    assign w_biased    = w_acc + {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias};
    assign w_activated = (r_relu_en && w_biased[ACC_W-1]) ? '0 : w_biased;

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle strobes; soft_clear forces IDLE and kills strobes
    always_comb begin
        w_state_next   = r_state;
        w_start_accept = 1'b0;
        w_len_bad      = 1'b0;
        w_mac_en       = 1'b0;
        w_finish       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_start_pend) begin
                    if (w_len_ok) begin
                        w_state_next   = RUN;
                        w_start_accept = 1'b1;
                    end else begin
                        w_len_bad = 1'b1;
                    end
                end
            end
            RUN: begin
                w_mac_en = 1'b1;
                if (w_idx_last) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                w_finish     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (w_soft_clear) begin
            w_state_next   = IDLE;
            w_start_accept = 1'b0;
            w_len_bad      = 1'b0;
            w_mac_en       = 1'b0;
            w_finish       = 1'b0;
        end
    end

    assign w_mac_clear = w_start_accept || w_soft_clear;

    neural_acc_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .i_clear (w_mac_clear),
        .i_en    (w_mac_en),
        .i_a     (r_in_buf[r_idx]),
        .i_b     (r_w_buf[r_idx]),
        .o_acc   (w_acc)
    );

    // Run control: pending start, index, done/len_err flags, result capture
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_start_pend <= 1'b0;
            r_idx        <= '0;
            r_done       <= 1'b0;
            r_len_err    <= 1'b0;
            r_done_irq   <= 1'b0;
            r_result     <= '0;
        end else begin
            r_start_pend <= 1'b0;
            r_done_irq   <= 1'b0;
            if (w_soft_clear) begin
                r_idx     <= '0;
                r_done    <= 1'b0;
                r_len_err <= 1'b0;
                r_result  <= '0;
            end else begin
                if (w_start_req && !busy) begin
                    r_start_pend <= 1'b1;
                end
                if (w_start_accept) begin
                    r_done <= 1'b0;
                    r_idx  <= '0;
                end
                if (w_len_bad) begin
                    r_len_err <= 1'b1;
                end
                if (w_mac_en) begin
                    r_idx <= r_idx + c_IDX_W'(1);
                end
                if (w_finish) begin
                    r_result   <= saturate_s32({{(64-ACC_W){w_activated[ACC_W-1]}}, w_activated});
                    r_done     <= 1'b1;
                    r_done_irq <= 1'b1;
                end
            end
        end
    end

    // Vector buffers, fill counters and push error flags
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_in_buf[i] <= '0;
                r_w_buf[i]  <= '0;
            end
            r_in_cnt <= '0;
            r_w_cnt  <= '0;
            r_ovf    <= 1'b0;
            r_wr_err <= 1'b0;
        end else if (w_soft_clear) begin
            r_in_cnt <= '0;
            r_w_cnt  <= '0;
            r_ovf    <= 1'b0;
            r_wr_err <= 1'b0;
        end else if (w_finish) begin
            r_in_cnt <= '0;
            r_w_cnt  <= '0;
            if (w_push_in || w_push_w) begin
                r_wr_err <= 1'b1;
            end
        end else if (w_push_in || w_push_w) begin
            if (busy) begin
                r_wr_err <= 1'b1;
            end else if (w_push_in) begin
                if (int'(r_in_cnt) < DEPTH) begin
                    r_in_buf[r_in_cnt[c_IDX_W-1:0]] <= reg_wr_data[DATA_W-1:0];
                    r_in_cnt <= r_in_cnt + c_CNT_W'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end else begin
                if (int'(r_w_cnt) < DEPTH) begin
                    r_w_buf[r_w_cnt[c_IDX_W-1:0]] <= reg_wr_data[DATA_W-1:0];
                    r_w_cnt <= r_w_cnt + c_CNT_W'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Configuration registers survive soft_clear
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_relu_en <= 1'b0;
            r_len     <= '0;
            r_bias    <= '0;
        end else if (reg_wr_en) begin
            if (reg_wr_addr == REG_CTRL) begin
                r_relu_en <= reg_wr_data[CTRL_RELU_BIT];
            end
            if (reg_wr_addr == REG_LEN) begin
                r_len <= reg_wr_data[3:0];
            end
            if (reg_wr_addr == REG_BIAS) begin
                r_bias <= reg_wr_data[DATA_W-1:0];
            end
        end
    end

    // Status word and read mux from current (pre-write) register values
    always_comb begin
        w_status                   = '0;
        w_status[STAT_BUSY_BIT]    = busy;
        w_status[STAT_DONE_BIT]    = r_done;
        w_status[STAT_OVF_BIT]     = r_ovf;
        w_status[STAT_LEN_ERR_BIT] = r_len_err;
        w_status[STAT_WR_ERR_BIT]  = r_wr_err;
        w_status[STAT_IN_CNT_LSB +: 8] = 8'(r_in_cnt);
        w_status[STAT_W_CNT_LSB  +: 8] = 8'(r_w_cnt);
        w_rd_mux = '0;
        case (reg_rd_addr)
            REG_CTRL:   w_rd_mux[CTRL_RELU_BIT] = r_relu_en;
            REG_LEN:    w_rd_mux = {28'd0, r_len};
            REG_BIAS:   w_rd_mux = {{(32-DATA_W){r_bias[DATA_W-1]}}, r_bias};
            REG_STATUS: w_rd_mux = w_status;
            REG_RESULT: w_rd_mux = r_result;
            default:    w_rd_mux = '0;
        endcase
    end

    // Registered read data, updated only on a read strobe
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rd_data <= '0;
        end else if (reg_rd_en) begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign reg_rd_data = r_rd_data;

endmodule
`default_nettype wire
